// File: rtl/exec_unit.sv
// Execution datapath: four operand registers, accumulator with carry/zero flags, and a
// valid/ready output register whose back-pressure stalls the program counter.
module exec_unit #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    ceo,
  input  logic [2:0]    alu_code,
  input  logic          ce,
  input  logic          cy_ce,
  input  logic          a_ce,
  input  logic          ld_en,
  input  logic [1:0]    ld_sel,
  input  logic [DW-1:0] ld_data,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [DW-1:0] acc,
  output logic          cy,
  output logic          z,
  output logic          stall,
  output logic          err_multi
);

  localparam logic [2:0] AluNop   = 3'b000;
  localparam logic [2:0] AluAdd   = 3'b001;
  localparam logic [2:0] AluSub   = 3'b010;
  localparam logic [2:0] AluAdc   = 3'b011;
  localparam logic [2:0] AluAnd   = 3'b100;
  localparam logic [2:0] AluOr    = 3'b101;
  localparam logic [2:0] AluXor   = 3'b110;
  localparam logic [2:0] AluPassb = 3'b111;

  logic [DW-1:0] r_q [4];
  logic [DW-1:0] a_q, out_data_q;
  logic          cy_q, z_q, out_valid_q, err_q;

  logic [DW-1:0] b_bus, alu_res;
  logic          alu_cy, multi_sel;
  logic [DW:0]   add_ext, adc_ext, sub_ext;

  // More than one select bit set: clear lowest set bit and see if anything remains.
  assign multi_sel = (ceo & (ceo - 4'd1)) != 4'd0;

  always_comb begin
    b_bus = '0;
    case (ceo)
      4'b0001: b_bus = r_q[0];
      4'b0010: b_bus = r_q[1];
      4'b0100: b_bus = r_q[2];
      4'b1000: b_bus = r_q[3];
      default: b_bus = '0;
    endcase
  end

  assign add_ext = {1'b0, a_q} + {1'b0, b_bus};
  assign adc_ext = add_ext + {{DW{1'b0}}, cy_q};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_ext = {1'b0, a_q} - {1'b0, b_bus};

  always_comb begin
    alu_res = a_q;
    alu_cy  = cy_q;
    case (alu_code)
      AluNop:   begin alu_res = a_q;             alu_cy = cy_q;        end
      AluAdd:   begin alu_res = add_ext[DW-1:0]; alu_cy = add_ext[DW]; end
      AluSub:   begin alu_res = sub_ext[DW-1:0]; alu_cy = sub_ext[DW]; end
      AluAdc:   begin alu_res = adc_ext[DW-1:0]; alu_cy = adc_ext[DW]; end
      AluAnd:   begin alu_res = a_q & b_bus;     alu_cy = 1'b0;        end
      AluOr:    begin alu_res = a_q | b_bus;     alu_cy = 1'b0;        end
      AluXor:   begin alu_res = a_q ^ b_bus;     alu_cy = 1'b0;        end
      AluPassb: begin alu_res = b_bus;           alu_cy = 1'b0;        end
      default:  begin alu_res = a_q;             alu_cy = cy_q;        end
    endcase
  end

  assign stall = ce & out_valid_q & ~out_ready;

  // Operand loads ignore stall so the loader is never blocked by the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
    end else if (ld_en) begin
      r_q[ld_sel] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      z_q   <= 1'b1;
      cy_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (!stall) begin
      if (a_ce) begin
        a_q <= alu_res;
        z_q <= (alu_res == '0);
      end
      if (cy_ce)     cy_q  <= alu_cy;
      if (multi_sel) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (ce && !stall) begin
      out_data_q  <= a_q;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc       = a_q;
  assign cy        = cy_q;
  assign z         = z_q;
  assign err_multi = err_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: arithmetic, flags, output handshake, stall and reset.
module tb_exec_unit;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    ceo;
  logic [2:0]    alu_code;
  logic          ce, cy_ce, a_ce, ld_en, out_ready;
  logic [1:0]    ld_sel;
  logic [DW-1:0] ld_data;
  logic          out_valid, cy, z, stall, err_multi;
  logic [DW-1:0] out_data, acc;

  int errors = 0;
  int checks = 0;

  exec_unit #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .ceo(ceo), .alu_code(alu_code), .ce(ce), .cy_ce(cy_ce),
    .a_ce(a_ce), .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .acc(acc), .cy(cy), .z(z), .stall(stall),
    .err_multi(err_multi)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ctl(input logic [3:0] c, input logic [2:0] op, input logic e,
                     input logic cye, input logic ae);
    ceo = c; alu_code = op; ce = e; cy_ce = cye; a_ce = ae;
  endtask

  task automatic idle();
    ctl(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
    ld_en = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    idle(); out_ready = 1'b0; ld_sel = 2'd0; ld_data = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if (acc !== 8'h00 || cy !== 1'b0 || z !== 1'b1) begin
      errors++; $display("FAIL reset_flags acc=%h cy=%b z=%b exp acc=00 cy=0 z=1", acc, cy, z);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || err_multi !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_out valid=%b data=%h err=%b stall=%b exp 0 00 0 0",
               out_valid, out_data, err_multi, stall);
    end
  endtask

  task automatic test_add();
    load(2'd0, 8'h05); load(2'd1, 8'h03); load(2'd2, 8'h01); load(2'd3, 8'hFF);
    ctl(4'b0001, 3'b001, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h05 || z !== 1'b0) begin
      errors++; $display("FAIL add_r0 acc=%h z=%b exp acc=05 z=0", acc, z);
    end
    ctl(4'b0010, 3'b001, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h08) begin
      errors++; $display("FAIL add_r1 acc=%h exp 08", acc);
    end
  endtask

  task automatic test_sub();
    ctl(4'b0100, 3'b010, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'h07 || cy !== 1'b0) begin
      errors++; $display("FAIL sub_nb acc=%h cy=%b exp acc=07 cy=0", acc, cy);
    end
    ctl(4'b0000, 3'b111, 1'b0, 1'b0, 1'b1); step();  // PASSB of empty bus clears A
    checks++;
    if (acc !== 8'h00 || z !== 1'b1) begin
      errors++; $display("FAIL passb_zero acc=%h z=%b exp acc=00 z=1", acc, z);
    end
    ctl(4'b0100, 3'b010, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'hFF || cy !== 1'b1 || z !== 1'b0) begin
      errors++; $display("FAIL sub_borrow acc=%h cy=%b z=%b exp acc=ff cy=1 z=0", acc, cy, z);
    end
  endtask

  task automatic test_carry();
    ctl(4'b0100, 3'b111, 1'b0, 1'b0, 1'b1); step();
    ctl(4'b1000, 3'b001, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'h00 || cy !== 1'b1 || z !== 1'b1) begin
      errors++; $display("FAIL add_wrap acc=%h cy=%b z=%b exp acc=00 cy=1 z=1", acc, cy, z);
    end
    ctl(4'b0001, 3'b011, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'h06 || cy !== 1'b0) begin
      errors++; $display("FAIL adc acc=%h cy=%b exp acc=06 cy=0", acc, cy);
    end
  endtask

  task automatic test_logic();
    ctl(4'b0001, 3'b110, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h03) begin
      errors++; $display("FAIL xor acc=%h exp 03", acc);
    end
    ctl(4'b0001, 3'b101, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h07) begin
      errors++; $display("FAIL or acc=%h exp 07", acc);
    end
    // Carry update alone: A and Z untouched.
    ctl(4'b1000, 3'b001, 1'b0, 1'b1, 1'b0); step();
    checks++;
    if (acc !== 8'h07 || cy !== 1'b1 || z !== 1'b0) begin
      errors++; $display("FAIL cy_only acc=%h cy=%b z=%b exp acc=07 cy=1 z=0", acc, cy, z);
    end
    ctl(4'b0001, 3'b100, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'h05 || cy !== 1'b0) begin
      errors++; $display("FAIL and acc=%h cy=%b exp acc=05 cy=0", acc, cy);
    end
    ctl(4'b0010, 3'b000, 1'b0, 1'b1, 1'b1); step();
    checks++;
    if (acc !== 8'h05 || cy !== 1'b0 || z !== 1'b0) begin
      errors++; $display("FAIL nop acc=%h cy=%b z=%b exp acc=05 cy=0 z=0", acc, cy, z);
    end
  endtask

  task automatic test_load_bypass();
    ld_en = 1'b1; ld_sel = 2'd0; ld_data = 8'h09;
    ctl(4'b0001, 3'b111, 1'b0, 1'b0, 1'b1); step();
    ld_en = 1'b0;
    checks++;
    if (acc !== 8'h05) begin
      errors++; $display("FAIL load_old acc=%h exp 05", acc);
    end
    step();
    checks++;
    if (acc !== 8'h09) begin
      errors++; $display("FAIL load_new acc=%h exp 09", acc);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    ctl(4'b0010, 3'b001, 1'b1, 1'b0, 1'b1);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_c1 stall=%b exp 0", stall);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h09 || acc !== 8'h0C) begin
      errors++;
      $display("FAIL capture1 valid=%b data=%h acc=%h exp 1 09 0c", out_valid, out_data, acc);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d stall=%b exp 1", i, stall);
      end
      step();
      checks++;
      if (acc !== 8'h0C || out_data !== 8'h09 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL frozen%0d acc=%h data=%h valid=%b exp 0c 09 1", i, acc, out_data,
                 out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL stall_release stall=%b exp 0", stall);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h0C || acc !== 8'h0F) begin
      errors++;
      $display("FAIL capture2 valid=%b data=%h acc=%h exp 1 0c 0f", out_valid, out_data, acc);
    end
    idle(); step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h0C) begin
      errors++; $display("FAIL drain valid=%b data=%h exp 0 0c", out_valid, out_data);
    end
  endtask

  task automatic test_multi();
    ctl(4'b0011, 3'b001, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h0F || err_multi !== 1'b1) begin
      errors++; $display("FAIL multi acc=%h err=%b exp acc=0f err=1", acc, err_multi);
    end
    idle(); step(); step(); step();
    checks++;
    if (err_multi !== 1'b1) begin
      errors++; $display("FAIL multi_sticky err=%b exp 1", err_multi);
    end
  endtask

  task automatic test_reset_mid();
    load(2'd0, 8'h42);
    ctl(4'b0001, 3'b111, 1'b0, 1'b1, 1'b1); step();
    out_ready = 1'b0;
    ctl(4'b0000, 3'b000, 1'b1, 1'b0, 1'b0); step();
    checks++;
    if (acc !== 8'h42 || out_valid !== 1'b1 || out_data !== 8'h42) begin
      errors++;
      $display("FAIL pre_rst acc=%h valid=%b data=%h exp 42 1 42", acc, out_valid, out_data);
    end
    idle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (acc !== 8'h00 || z !== 1'b1 || cy !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== 8'h00 || err_multi !== 1'b0) begin
      errors++;
      $display("FAIL async_rst acc=%h z=%b cy=%b valid=%b data=%h err=%b exp 00 1 0 0 00 0",
               acc, z, cy, out_valid, out_data, err_multi);
    end
    step();
    rst = 1'b0;
    ctl(4'b0001, 3'b111, 1'b0, 1'b0, 1'b1); step();
    checks++;
    if (acc !== 8'h00 || z !== 1'b1) begin
      errors++; $display("FAIL rst_regs acc=%h z=%b exp acc=00 z=1", acc, z);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_carry();
    test_logic();
    test_load_bypass();
    test_back_to_back();
    test_multi();
    test_reset_mid();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execution datapath that consumes the per-step control word driven by the microprogram ROM: `ceo`, `alu_code`, `ce`, `cy_ce`, `a_ce`.
- Holds four operand registers R0..R3, the accumulator A, a carry flag CY, a zero flag Z, and a valid/ready output register.
- Sits between the program-ROM control outputs and the external result consumer.
- Generates `stall`, which an enable-capable PC uses to hold the current address.

Parameters:
- DW, 8, datapath width of R0..R3, A and `out_data`.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ceo  in  4  one-hot operand select: bit i drives Ri onto the B bus.
- alu_code  in  3  ALU operation; encodings in defines.sv, values listed below.
- ce  in  1  output capture enable: out_data <= A.
- cy_ce  in  1  carry flag update enable.
- a_ce  in  1  accumulator (and Z) update enable.
- ld_en  in  1  operand register write strobe.
- ld_sel  in  2  operand register index for the write.
- ld_data  in  DW  operand register write data.
- out_ready  in  1  consumer accepts out_data.
- out_valid  out  1  out_data holds an unconsumed value.
- out_data  out  DW  captured accumulator value.
- acc  out  DW  current A.
- cy  out  1  current CY.
- z  out  1  current Z.
- stall  out  1  combinational; hold PC and control word this cycle.
- err_multi  out  1  sticky flag: ceo had more than one bit set.

Behaviour:
- Reset (async, active-high): R0..R3=0, A=0, CY=0, Z=1, out_data=0, out_valid=0, err_multi=0.
- B bus (combinational):
  - ceo==0: B=0.
  - ceo one-hot: B=Ri.
  - More than one bit set: B=0, and err_multi is set at the next edge. err_multi clears only on reset.
- ALU result R and carry-out C, all arithmetic modulo 2^DW:
  - 000 NOP: R=A, C=CY.
  - 001 ADD: R=A+B, C=carry.
  - 010 SUB: R=A-B, C=borrow (1 iff A<B, unsigned).
  - 011 ADC: R=A+B+CY, C=carry.
  - 100 AND: R=A&B, C=0.
  - 101 OR: R=A|B, C=0.
  - 110 XOR: R=A^B, C=0.
  - 111 PASSB: R=B, C=0.
- Single-cycle latency: the control word present in cycle n takes effect at the rising edge ending cycle n.
- State updates:
  - a_ce=1: A<=R, Z<=(R==0).
  - cy_ce=1: CY<=C.
  - Each enable is independent; Z changes only with A.
- Output handshake:
  - stall = ce & out_valid & ~out_ready.
  - When ce=1 and stall=0: out_data<=A (value before any same-cycle A update), out_valid<=1.
  - When out_valid & out_ready and no capture this cycle: out_valid<=0.
  - Capture and accept in the same cycle: out_data takes the new value and out_valid stays 1.
- Stall:
  - While stall=1, updates to A, CY, Z, out_data and err_multi are suppressed.
  - The control word must be held by the PC and re-executes when stall drops.
- Operand load:
  - ld_en=1: R[ld_sel]<=ld_data. Not gated by stall.
  - Reading the same register in the same cycle sees the old value.
- Reset asserted mid-operation clears all state immediately, including a pending out_valid; no partial update survives.

Test Plan:
- Reset, load R0=5, R1=3, R2=1, R3=0xFF. Apply ADD ceo=0001, a_ce=1 → A=5, Z=0. Then ADD ceo=0010 → A=8.
- A=8: SUB ceo=0100 with cy_ce=1 → A=7, CY=0. Then A=0: SUB R2 → A=0xFF, CY=1, Z=0.
- A=0x01: ADD ceo=1000 (R3=0xFF) with cy_ce=1 → A=0x00, CY=1, Z=1. Next ADC ceo=0001 (R0=5) → A=6, CY=0.
- ce=1 with out_ready=0 for 3 cycles → out_valid=1 and out_data=A after cycle 1. Cycles 2–3: stall=1, A frozen. Raise out_ready → capture proceeds, stall=0.
- ceo=0011 with ADD, a_ce=1 → B=0, A unchanged, err_multi=1, which persists until rst.
- Assert rst while out_valid=1 and A=0x42 → all outputs go to reset values asynchronously; Z=1.
